pipe_arbiter: RTL and testbench
===============================

PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the clock edges from pipe_datain to pipe_dataout of the attached pipeline; legal range 1..8.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid, req1_valid  in  1  each  requester has a word to issue.
REQ-005 SHALL have ports req0_data, req1_data  in  16 each  requester payload.
REQ-006 SHALL have ports req0_ready, req1_ready  out  1 each  grant; transfer = valid & ready.
REQ-007 SHALL have port pipe_datain  out  16  registered word driven into the pipeline.
REQ-008 SHALL have port pipe_dataout  in  16  pipeline output.
REQ-009 SHALL have ports rsp0_valid, rsp1_valid  out  1 each  pipe_dataout belongs to that requester this cycle.
REQ-010 SHALL have port rsp_data  out  16  equal to pipe_dataout.
REQ-011 SHALL have ports issue_cnt0, issue_cnt1  out  16 each  saturating per-requester transfer counts.
REQ-012 SHALL have port busy  out  1  at least one word is in flight.

Function
REQ-013 SHALL assert at most one readyN per cycle, and readyN only while reqN_valid is high (combinational grant).
REQ-014 SHALL grant the sole valid requester when only one is valid.
REQ-015 SHALL grant the requester not granted last when both are valid, giving round-robin order.
REQ-016 SHALL update the last-grant pointer only on a transfer edge; idle cycles leave it unchanged.
REQ-017 SHALL load pipe_datain with the granted data on a transfer edge, and load 0x0000 on edges with no transfer.
REQ-018 SHALL push a tag {valid, id} into an internal LATENCY-stage delay line on every edge, with valid=0 when no transfer occurs.
REQ-019 SHALL assert rspN_valid for exactly one cycle, starting LATENCY edges after the transfer edge, where N is the issuing requester.
REQ-020 SHALL never assert rsp0_valid and rsp1_valid together.
REQ-021 SHALL drive rsp_data = pipe_dataout combinationally, with a value regardless of the rsp valids.
REQ-022 SHALL increment issue_cntN on each requester-N transfer and hold at 0xFFFF.
REQ-023 SHALL assert busy while any delay-line tag is valid.
REQ-024 SHALL sustain back-to-back transfers every cycle with no bubbles and no backpressure from the response side.

Reset
REQ-025 SHALL, while rst_n is low, immediately force pipe_datain=0, all tags invalid, both counters=0, busy=0, all rspN_valid=0, and last-grant=1.
REQ-026 SHALL, with last-grant=1 after reset, grant requester 0 first on a simultaneous request.
REQ-027 SHALL drop words in flight when reset asserts mid-operation: pipeline contents are ignored because their tags are cleared, and no rspN_valid follows.
REQ-028 SHALL hold readyN low during reset.

Structure
REQ-029 SHALL put DATA_W=16, CNT_W=16, ID_W=1 and the tag struct {valid, id} in shared package pipe_arb_pkg.
REQ-030 SHALL implement the LATENCY-stage tag delay line as sub-module tag_delay_line.
REQ-031 SHALL keep the arbitration, issue register and counters in pipe_arbiter; the datapath pipeline stays external.

Verification
REQ-032 SHALL cover a single request: LATENCY=4, req0 sends 0x1234 at edge 10 -> pipe_datain=0x1234 after edge 10; rsp0_valid high only in the cycle after edge 14 with rsp_data=0x1234.
REQ-033 SHALL cover contention: both valid continuously from reset release for 6 cycles -> grants 0,1,0,1,0,1; responses in the same order; issue_cnt0=issue_cnt1=3.
REQ-034 SHALL cover streaming: req1 valid for 8 consecutive cycles with data 1..8 -> 8 consecutive rsp1_valid cycles carrying 1..8; busy stays high throughout.
REQ-035 SHALL cover reset mid-flight: rst_n low 2 edges after three transfers -> no rsp valid at any later cycle; counters=0; busy=0.
REQ-036 SHALL cover saturation: issue_cnt0 preloaded near 0xFFFF, then 3 more req0 transfers -> issue_cnt0 holds at 0xFFFF.
REQ-037 SHALL cover the idle cycle: no request on an edge -> pipe_datain=0x0000 and no rsp valid LATENCY edges later; the bench models the pipeline as a LATENCY-deep delay.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_arb_pkg                                                 |
// | Description : Shared widths, the in-flight tag type and a saturating       |
// |               increment helper for the pipe_arbiter slice.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_arb_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;
   localparam int ID_W   = 1;

   // One tag travels alongside every word pushed into the external pipeline.
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   localparam int   TAG_W    = $bits(tag_t);
   localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tag_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tag_delay_line                                               |
// | Description : LATENCY-stage shift register of {valid,id} tags that tracks  |
// |               which requester owns each word in the external pipeline.     |
// | Ports       : clk, rst_n        - clock, async active-low reset            |
// |               tag_i             - tag entering stage 0 every edge          |
// |               tag_o             - tag leaving the last stage               |
// |               any_valid_o       - some stage holds a valid tag             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tag_delay_line
   import pipe_arb_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o,
   output logic             any_valid_o
);

   tag_t stage_q [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= TAG_IDLE;
         end
      end else begin
         stage_q[0] <= tag_t'(tag_i);
         for (int i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   always_comb begin
      any_valid_o = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         any_valid_o = any_valid_o | stage_q[i].valid;
      end
   end

   assign tag_o = stage_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/pipe_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_arbiter                                                 |
// | Description : Round-robin arbiter feeding two requesters into one external |
// |               fixed-latency pipeline, with response routing by tag.        |
// | Ports       : clk, rst_n                 - clock, async active-low reset   |
// |               reqN_valid/data/ready      - requester handshakes (N=0,1)    |
// |               pipe_datain / pipe_dataout - external pipeline in / out      |
// |               rspN_valid, rsp_data       - routed pipeline response        |
// |               issue_cnt0/1               - saturating transfer counters    |
// |               busy                       - a word is in flight             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_arbiter
   import pipe_arb_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req0_ready,
   output logic              req1_ready,
   output logic [DATA_W-1:0] pipe_datain,
   input  logic [DATA_W-1:0] pipe_dataout,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [CNT_W-1:0]  issue_cnt0,
   output logic [CNT_W-1:0]  issue_cnt1,
   output logic              busy
);

   logic              last_q, last_d;     // id of the most recent grant
   logic [DATA_W-1:0] din_q, din_d;
   tag_t              issue_tag_q, issue_tag_d;
   logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   logic              gnt0, gnt1, xfer;
   logic [TAG_W-1:0]  out_tag_bits;
   tag_t              out_tag;
   logic              line_busy;

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_q;    // last went to 1, so 0 goes next
            gnt1 = !last_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign xfer       = gnt0 | gnt1;

   always_comb begin
      last_d      = last_q;
      din_d       = '0;
      issue_tag_d = TAG_IDLE;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      if (xfer) begin
         last_d         = gnt1;
         din_d          = gnt1 ? req1_data : req0_data;
         issue_tag_d    = '{valid: 1'b1, id: gnt1};
         if (gnt0) cnt0_d = sat_inc(cnt0_q);
         if (gnt1) cnt1_d = sat_inc(cnt1_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= 1'b1;
         din_q       <= '0;
         issue_tag_q <= TAG_IDLE;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         last_q      <= last_d;
         din_q       <= din_d;
         issue_tag_q <= issue_tag_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   // The issue tag sits beside pipe_datain; the delay line then adds the
   // LATENCY edges the external pipeline takes to move that word to its output.
   tag_delay_line #(
      .LATENCY     (LATENCY)
   ) u_tag_delay_line (
      .clk         (clk),
      .rst_n       (rst_n),
      .tag_i       (issue_tag_q),
      .tag_o       (out_tag_bits),
      .any_valid_o (line_busy)
   );

   assign out_tag     = tag_t'(out_tag_bits);
   assign rsp0_valid  = out_tag.valid && (out_tag.id == 1'b0);
   assign rsp1_valid  = out_tag.valid && (out_tag.id == 1'b1);
   assign rsp_data    = pipe_dataout;
   assign pipe_datain = din_q;
   assign issue_cnt0  = cnt0_q;
   assign issue_cnt1  = cnt1_q;
   assign busy        = issue_tag_q.valid | line_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_arbiter                                              |
// | Description : Randomised scoreboard bench for pipe_arbiter with the        |
// |               external pipeline modelled as a LATENCY-deep delay.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_arbiter;
   import pipe_arb_pkg::*;

   localparam int LAT = 4;

   typedef struct {
      int          id;
      logic [15:0] data;
      int          t;       // edge number of the transfer
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0] req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready;
   logic [15:0] pipe_datain, pipe_dataout, rsp_data;
   logic        rsp0_valid, rsp1_valid, busy;
   logic [15:0] issue_cnt0, issue_cnt1;

   pipe_arbiter #(.LATENCY(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid),
      .req1_valid   (req1_valid),
      .req0_data    (req0_data),
      .req1_data    (req1_data),
      .req0_ready   (req0_ready),
      .req1_ready   (req1_ready),
      .pipe_datain  (pipe_datain),
      .pipe_dataout (pipe_dataout),
      .rsp0_valid   (rsp0_valid),
      .rsp1_valid   (rsp1_valid),
      .rsp_data     (rsp_data),
      .issue_cnt0   (issue_cnt0),
      .issue_cnt1   (issue_cnt1),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // External pipeline: plain delay, never reset.
   logic [15:0] pipe_m [LAT];
   always @(posedge clk) begin
      pipe_m[0] <= pipe_datain;
      for (int i = 1; i < LAT; i++) pipe_m[i] <= pipe_m[i-1];
   end
   assign pipe_dataout = pipe_m[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model state
   exp_t        sbq[$];
   int          last_m = 1;
   int          cnt_m[2] = '{0, 0};
   logic [15:0] din_m = '0;

   // One clock of stimulus; entered and left at a falling edge.
   task automatic step(input logic v0, input logic v1, input logic [15:0] d0, input logic [15:0] d1);
      int   gid;
      exp_t e;
      req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
      #1;
      gid = -1;
      if (v0 && v1) gid = (last_m == 0) ? 1 : 0;
      else if (v0)  gid = 0;
      else if (v1)  gid = 1;
      chk("ready0", {31'b0, req0_ready}, {31'b0, gid == 0});
      chk("ready1", {31'b0, req1_ready}, {31'b0, gid == 1});
      @(posedge clk);
      #1;
      if (gid >= 0) begin
         e.id = gid; e.data = (gid == 0) ? d0 : d1; e.t = cyc;
         sbq.push_back(e);
         last_m = gid;
         cnt_m[gid] = (cnt_m[gid] < 65535) ? cnt_m[gid] + 1 : 65535;
         din_m = e.data;
      end else begin
         din_m = 16'h0000;
      end
      chk("pipe_datain", {16'b0, pipe_datain}, {16'b0, din_m});
      chk("issue_cnt0", {16'b0, issue_cnt0}, cnt_m[0]);
      chk("issue_cnt1", {16'b0, issue_cnt1}, cnt_m[1]);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      sbq.delete();
      last_m = 1; cnt_m = '{0, 0}; din_m = '0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rst_ready0", {31'b0, req0_ready}, 0);
      chk("rst_ready1", {31'b0, req1_ready}, 0);
      chk("rst_pipe_datain", {16'b0, pipe_datain}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_cnt0", {16'b0, issue_cnt0}, 0);
      chk("rst_cnt1", {16'b0, issue_cnt1}, 0);
      chk("rst_rsp", {30'b0, rsp1_valid, rsp0_valid}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   // Response monitor
   logic mon_busy;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         mon_busy = 1'b0;
         foreach (sbq[i]) if (cyc <= sbq[i].t + LAT) mon_busy = 1'b1;
         chk("busy", {31'b0, busy}, {31'b0, mon_busy});
         if (rsp0_valid && rsp1_valid) begin
            chk("rsp_both", 2'b11, 2'b00);
         end else if (rsp0_valid || rsp1_valid) begin
            if (sbq.size() == 0) begin
               chk("rsp_unexpected", {30'b0, rsp1_valid, rsp0_valid}, 0);
            end else begin
               mon_e = sbq.pop_front();
               chk("rsp_id", {31'b0, rsp1_valid}, mon_e.id);
               chk("rsp_data", {16'b0, rsp_data}, {16'b0, mon_e.data});
               chk("rsp_cycle", cyc, mon_e.t + LAT);
            end
         end else if (sbq.size() != 0 && sbq[0].t + LAT <= cyc) begin
            mon_e = sbq.pop_front();
            chk("rsp_missing", 0, {31'b0, 1'b1});
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      do_reset();

      // Contention straight out of reset: 0,1,0,1,0,1
      for (int i = 0; i < 6; i++) step(1, 1, 16'($urandom), 16'($urandom));
      chk("contend_cnt0", {16'b0, issue_cnt0}, 3);
      chk("contend_cnt1", {16'b0, issue_cnt1}, 3);
      repeat (LAT + 2) step(0, 0, 0, 0);

      // Single request, then idle edges
      step(1, 0, 16'h1234, 16'hdead);
      repeat (LAT + 2) step(0, 0, 16'hffff, 16'hffff);

      // Streaming on requester 1
      for (int i = 1; i <= 8; i++) step(0, 1, 16'h0, 16'(i));
      repeat (LAT + 2) step(0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      repeat (LAT + 2) step(0, 0, 0, 0);

      // Reset with words in flight
      for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom), 0);
      repeat (2) step(0, 0, 0, 0);
      do_reset();
      repeat (LAT + 4) step(0, 0, 0, 0);

      // Saturation of issue_cnt0
      for (int i = 0; i < 65538; i++) step(1, 0, 16'($urandom), 0);
      chk("sat_cnt0", {16'b0, issue_cnt0}, 32'h0000_ffff);
      repeat (LAT + 3) step(0, 0, 0, 0);

      chk("sb_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
